// File: rtl/qsgmii_pcs_pkg.sv
// Shared definitions for the QSGMII PCS transmit path: code-group constants,
// the legal K-symbol set, FSM state type and the per-lane symbol record.
package qsgmii_pcs_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] K30_7 = 8'hFE;

    // Only these bytes are legal with k=1; anything else is replaced by K30_7.
    localparam logic [11:0][7:0] VALID_K = {
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
        8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    // /I2/ halves as full 4-lane words: lane 0 carries K28.1, lanes 1-3 K28.5.
    localparam logic [31:0] IDLE_K_TXD = {K28_5, K28_5, K28_5, K28_1};
    localparam logic [31:0] IDLE_D_TXD = {D16_2, D16_2, D16_2, D16_2};

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
    } pcs_sym_t;

    function automatic logic is_valid_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (b == VALID_K[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/qsgmii_pcs_tx_lane_sub.sv
// One QSGMII lane: validates K symbols and applies the comma rule
// (K28.1 on lane 0, K28.5 elsewhere). Purely combinational.
module qsgmii_pcs_tx_lane_sub
    import qsgmii_pcs_pkg::*;
#(
    parameter bit IS_LANE0 = 1'b0
) (
    input  pcs_sym_t sym_in,
    output pcs_sym_t sym_out,
    output logic     k_err
);

    // Data bytes pass untouched; only k=1 bytes are policed or rewritten.
    always_comb begin
        sym_out = sym_in;
        k_err   = 1'b0;
        if (sym_in.k) begin
            if (!is_valid_k(sym_in.d)) begin
                sym_out.d = K30_7;
                k_err     = 1'b1;
            end else if (IS_LANE0 && sym_in.d == K28_5) begin
                sym_out.d = K28_1;
            end else if (!IS_LANE0 && sym_in.d == K28_1) begin
                sym_out.d = K28_5;
            end
        end
    end

endmodule

// File: rtl/qsgmii_pcs_tx_mux.sv
// QSGMII PCS TX mux: four SGMII 8b/K streams -> one 4-lane word for the
// 8b/10b encoder. Startup /I2/ idle run, then a 2-stage pipeline
// (input register, substitution + lane mux into output register).
// Optional per-lane invalid-K counters: define QSGMII_TX_ERR_CNT_EN.
module qsgmii_pcs_tx_mux
    import qsgmii_pcs_pkg::*;
#(
    parameter int INIT_IDLE_CYC = 16,
    parameter int PIPE_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  p0_pcs_txd_in,
    input  logic        p0_pcs_txk_in,
    input  logic [7:0]  p1_pcs_txd_in,
    input  logic        p1_pcs_txk_in,
    input  logic [7:0]  p2_pcs_txd_in,
    input  logic        p2_pcs_txk_in,
    input  logic [7:0]  p3_pcs_txd_in,
    input  logic        p3_pcs_txk_in,
    output logic [31:0] pcs_txd,
    output logic [3:0]  pcs_txk,
    output logic        tx_ready
`ifdef QSGMII_TX_ERR_CNT_EN
    ,
    output logic [15:0] p0_err_cnt,
    output logic [15:0] p1_err_cnt,
    output logic [15:0] p2_err_cnt,
    output logic [15:0] p3_err_cnt
`endif
);

    localparam int              CNT_W    = $clog2(INIT_IDLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(INIT_IDLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_IDLE_CYC - 1);

    tx_state_t  state, state_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
    logic       phase_d;   // output currently shows the D half of /I2/

    logic [PIPE_STAGES-1:0]          vld_pipe;
    pcs_sym_t [NUM_LANES-1:0]        s1_sym;
    pcs_sym_t [NUM_LANES-1:0]        s2_sym;
    logic     [NUM_LANES-1:0]        k_err;

    assign tx_ready = (state == RUN);

    // FSM and startup idle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Leave INIT only once enough idles are out and this cycle closes an /I2/ pair.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        if (state == INIT) begin
            if (idle_cnt != CNT_MAX) idle_cnt_nxt = idle_cnt + CNT_W'(1);
            if (idle_cnt >= CNT_LAST && phase_d) state_nxt = RUN;
        end
    end

    // Stage 1: capture all ports; the valid bit marks words taken in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sym   <= '0;
            vld_pipe <= '0;
        end else begin
            s1_sym[0] <= '{d: p0_pcs_txd_in, k: p0_pcs_txk_in};
            s1_sym[1] <= '{d: p1_pcs_txd_in, k: p1_pcs_txk_in};
            s1_sym[2] <= '{d: p2_pcs_txd_in, k: p2_pcs_txk_in};
            s1_sym[3] <= '{d: p3_pcs_txd_in, k: p3_pcs_txk_in};
            vld_pipe  <= {vld_pipe[PIPE_STAGES-2:0], (state == RUN)};
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        qsgmii_pcs_tx_lane_sub #(
            .IS_LANE0 (i == 0)
        ) u_lane (
            .sym_in  (s1_sym[i]),
            .sym_out (s2_sym[i]),
            .k_err   (k_err[i])
        );
    end

    // Stage 2: user data once stage 1 is valid, otherwise keep alternating /I2/.
    // That fill covers the pipeline gap after tx_ready rises without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcs_txd <= IDLE_K_TXD;
            pcs_txk <= 4'hF;
            phase_d <= 1'b0;
        end else begin
            if (vld_pipe[0]) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    pcs_txd[8*i +: 8] <= s2_sym[i].d;
                    pcs_txk[i]        <= s2_sym[i].k;
                end
            end else if (phase_d) begin
                pcs_txd <= IDLE_K_TXD;
                pcs_txk <= 4'hF;
            end else begin
                pcs_txd <= IDLE_D_TXD;
                pcs_txk <= 4'h0;
            end
            // Phase is only meaningful while idles can still be emitted.
            if (!vld_pipe[PIPE_STAGES-1]) phase_d <= ~phase_d;
        end
    end

`ifdef QSGMII_TX_ERR_CNT_EN
    logic [NUM_LANES-1:0][15:0] err_cnt;

    // Saturating invalid-K counters, updated on the edge the FE reaches pcs_txd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (vld_pipe[0] && k_err[i] && err_cnt[i] != 16'hFFFF)
                    err_cnt[i] <= err_cnt[i] + 16'd1;
            end
        end
    end

    assign p0_err_cnt = err_cnt[0];
    assign p1_err_cnt = err_cnt[1];
    assign p2_err_cnt = err_cnt[2];
    assign p3_err_cnt = err_cnt[3];
`else
    logic unused_k_err;
    assign unused_k_err = ^k_err;
`endif

endmodule

// File: tb/tb_qsgmii_pcs_tx_mux.sv
// Bench for qsgmii_pcs_tx_mux: startup idle sequence (16 and 3 idle cycles),
// vector table, random traffic through a 2-deep scoreboard, mid-run reset.
module tb_qsgmii_pcs_tx_mux;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  err;
    } exp_t;

    typedef struct packed {
        logic [31:0] in_d;
        logic [3:0]  in_k;
        logic [31:0] ex_d;
        logic [3:0]  ex_k;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_d;
    logic [3:0]  in_k;
    logic [31:0] txd16, txd3;
    logic [3:0]  txk16, txk3;
    logic        rdy16, rdy3;
`ifdef QSGMII_TX_ERR_CNT_EN
    logic [3:0][15:0] ec16, ec3;
    int               merr[4];
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t tbl[10];
    logic [7:0] vk[12];

    always #5 clk = ~clk;

    qsgmii_pcs_tx_mux #(.INIT_IDLE_CYC(16), .PIPE_STAGES(2)) dut16 (
        .clk(clk), .rst(rst),
        .p0_pcs_txd_in(in_d[7:0]),   .p0_pcs_txk_in(in_k[0]),
        .p1_pcs_txd_in(in_d[15:8]),  .p1_pcs_txk_in(in_k[1]),
        .p2_pcs_txd_in(in_d[23:16]), .p2_pcs_txk_in(in_k[2]),
        .p3_pcs_txd_in(in_d[31:24]), .p3_pcs_txk_in(in_k[3]),
        .pcs_txd(txd16), .pcs_txk(txk16), .tx_ready(rdy16)
`ifdef QSGMII_TX_ERR_CNT_EN
        , .p0_err_cnt(ec16[0]), .p1_err_cnt(ec16[1]),
        .p2_err_cnt(ec16[2]), .p3_err_cnt(ec16[3])
`endif
    );

    qsgmii_pcs_tx_mux #(.INIT_IDLE_CYC(3), .PIPE_STAGES(2)) dut3 (
        .clk(clk), .rst(rst),
        .p0_pcs_txd_in(in_d[7:0]),   .p0_pcs_txk_in(in_k[0]),
        .p1_pcs_txd_in(in_d[15:8]),  .p1_pcs_txk_in(in_k[1]),
        .p2_pcs_txd_in(in_d[23:16]), .p2_pcs_txk_in(in_k[2]),
        .p3_pcs_txd_in(in_d[31:24]), .p3_pcs_txk_in(in_k[3]),
        .pcs_txd(txd3), .pcs_txk(txk3), .tx_ready(rdy3)
`ifdef QSGMII_TX_ERR_CNT_EN
        , .p0_err_cnt(ec3[0]), .p1_err_cnt(ec3[1]),
        .p2_err_cnt(ec3[2]), .p3_err_cnt(ec3[3])
`endif
    );

    // Reference substitution, written from the comma/valid-K rules.
    function automatic exp_t model(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.d = d; e.k = k; e.err = 4'h0;
        for (int l = 0; l < 4; l++) begin
            logic [7:0] b;
            b = d[8*l +: 8];
            if (k[l]) begin
                case (b)
                    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                    8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE: begin
                        if (l == 0 && b == 8'hBC) e.d[7:0] = 8'h3C;
                        if (l != 0 && b == 8'h3C) e.d[8*l +: 8] = 8'hBC;
                    end
                    default: begin
                        e.d[8*l +: 8] = 8'hFE;
                        e.err[l] = 1'b1;
                    end
                endcase
            end
        end
        return e;
    endfunction

    function automatic logic [35:0] idle_word(input int c);
        return (c % 2 == 0) ? {4'hF, 32'hBCBC_BC3C} : {4'h0, 32'h5050_5050};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push_drive(input logic [31:0] d, input logic [3:0] k,
                              input logic [31:0] ed, input logic [3:0] ek);
        exp_t m;
        m = model(d, k);
        in_d = d;
        in_k = k;
        sb.push_back('{ed, ek, m.err});
`ifdef QSGMII_TX_ERR_CNT_EN
        for (int l = 0; l < 4; l++) merr[l] += int'(m.err[l]);
`endif
    endtask

    task automatic rand_word(output logic [31:0] d, output logic [3:0] k);
        for (int l = 0; l < 4; l++) begin
            case ($urandom_range(0, 3))
                0: begin d[8*l +: 8] = 8'($urandom); k[l] = 1'b0; end
                1: begin d[8*l +: 8] = 8'($urandom); k[l] = 1'b1; end
                2: begin d[8*l +: 8] = ($urandom_range(0, 1) != 0) ? 8'hBC : 8'h3C; k[l] = 1'b1; end
                default: begin d[8*l +: 8] = vk[$urandom_range(0, 11)]; k[l] = 1'b1; end
            endcase
        end
    endtask

    task automatic push_rand();
        logic [31:0] d;
        logic [3:0]  k;
        exp_t m;
        rand_word(d, k);
        m = model(d, k);
        push_drive(d, k, m.d, m.k);
    endtask

    // Compare the oldest pending word once it is two cycles old.
    task automatic sb_pop(input int n);
        exp_t e;
        if (sb.size() == n) begin
            e = sb.pop_front();
            chk("run_word", {txk16, txd16}, {e.k, e.d});
        end
    endtask

    task automatic flush();
        step(); sb_pop(2);
        step(); sb_pop(1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_txd16", {txk16, txd16}, {4'hF, 32'hBCBC_BC3C});
        chk("rst_rdy16", {35'd0, rdy16}, 36'd0);
        chk("rst_txd3",  {txk3, txd3},   {4'hF, 32'hBCBC_BC3C});
        chk("rst_rdy3",  {35'd0, rdy3},  36'd0);
`ifdef QSGMII_TX_ERR_CNT_EN
        for (int l = 0; l < 4; l++) chk("rst_err_cnt", {20'd0, ec16[l]}, 36'd0);
`endif
    endtask

    // Called in the cycle right after reset release (cycle 0).
    task automatic init_seq();
        logic [31:0] r3d;
        logic [3:0]  r3k;
        exp_t        m3;
        r3d = '0; r3k = '0;
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) step();
            chk("init_txd16", {txk16, txd16}, idle_word(c));
            chk("init_rdy16", {35'd0, rdy16}, {35'd0, (c >= 16)});
            if (c <= 5) chk("init_txd3", {txk3, txd3}, idle_word(c));
            chk("init_rdy3", {35'd0, rdy3}, {35'd0, (c >= 4)});
            if (c == 6) begin
                m3 = model(r3d, r3k);
                chk("dut3_first_word", {txk3, txd3}, {m3.k, m3.d});
            end
            if (c >= 16) begin
                push_rand();
            end else begin
                in_d = $urandom;
                in_k = 4'($urandom_range(0, 15));
                if (c == 4) begin r3d = in_d; r3k = in_k; end
            end
        end
    endtask

    task automatic chk_err_cnt();
`ifdef QSGMII_TX_ERR_CNT_EN
        for (int l = 0; l < 4; l++) chk("err_cnt", {20'd0, ec16[l]}, 36'(merr[l]));
`endif
    endtask

    initial begin
        vk = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
               8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        tbl[0] = '{32'hBC50_3CBC, 4'hB, 32'hBC50_BC3C, 4'hB};
        tbl[1] = '{32'hBCAB_2211, 4'h4, 32'hBCFE_2211, 4'h4};
        tbl[2] = '{32'hBD3D_FF00, 4'hF, 32'hFEFE_FEFE, 4'hF};
        tbl[3] = '{32'hFDFB_F71C, 4'hF, 32'hFDFB_F71C, 4'hF};
        tbl[4] = '{32'h3C3C_3CBC, 4'hC, 32'hBCBC_3CBC, 4'hC};
        tbl[5] = '{32'hFE5C_BC3C, 4'hF, 32'hFE5C_BC3C, 4'hF};
        tbl[6] = '{32'hDC9C_7CFE, 4'hB, 32'hDC9C_7CFE, 4'hB};
        tbl[7] = '{32'h00FC_DCBC, 4'h7, 32'h00FC_DC3C, 4'h7};
        tbl[8] = '{32'h3C3C_3C3C, 4'hF, 32'hBCBC_BC3C, 4'hF};
        tbl[9] = '{32'h0102_BCBC, 4'hF, 32'hFEFE_BC3C, 4'hF};
`ifdef QSGMII_TX_ERR_CNT_EN
        for (int l = 0; l < 4; l++) merr[l] = 0;
`endif

        rst = 1'b1; in_d = '0; in_k = '0;
        step(); step();
        chk_reset_vals();
        rst = 1'b0;
        init_seq();

        for (int i = 0; i < 10; i++) begin
            step(); sb_pop(2);
            push_drive(tbl[i].in_d, tbl[i].in_k, tbl[i].ex_d, tbl[i].ex_k);
        end
        flush();
        chk_err_cnt();

        for (int i = 0; i < 10000; i++) begin
            step(); sb_pop(2);
            push_rand();
        end

        // Asynchronous reset in the middle of a cycle, words still in flight.
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        sb.delete();
`ifdef QSGMII_TX_ERR_CNT_EN
        for (int l = 0; l < 4; l++) merr[l] = 0;
`endif
        step();
        chk_reset_vals();
        rst = 1'b0;
        init_seq();
        for (int i = 0; i < 200; i++) begin
            step(); sb_pop(2);
            push_rand();
        end
        flush();
        chk_err_cnt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
